// File: rtl/aes_ctr_seq.sv
// aes_ctr_seq: hardware sequencer driving the AES-CTR core 32-bit register port.
// Loads key/config, initialises the core, then runs one block per client request.
module aes_ctr_seq #(
    parameter int unsigned POLL_LIMIT = 1024,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              key_load,
    input  logic [255:0]      key,
    input  logic              keylen,
    output logic              busy,
    output logic              key_ready,
    output logic              err,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [127:0]      blk_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [127:0]      res_data,
    output logic              reg_req,
    output logic              reg_we,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [31:0]       reg_wdata,
    input  logic              reg_ack,
    input  logic [31:0]       reg_rdata
);
    localparam int unsigned PCW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        IDLE, KEY_WR, CFG_WR, INIT_SET, INIT_CLR, WAIT_RDY, READY,
        BLK_WR, NEXT_SET, NEXT_CLR, WAIT_VLD, RES_RD, RES_OUT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        idx;
    logic [PCW-1:0]    poll_cnt;
    logic [31:0]       key_w [8];
    logic [31:0]       blk_w [4];
    logic              keylen_q;
    logic              acc_done;
    logic              poll_to;
    logic              key_acc;
    logic              blk_acc;
    logic              acc_need;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;

    assign acc_done = reg_req & reg_ack;

    // state register
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state logic; key_load takes priority over a block in READY
    always_comb begin
        state_nxt = state;
        poll_to   = 1'b0;
        key_acc   = 1'b0;
        blk_acc   = 1'b0;
        case (state)
            IDLE:     if (key_load) begin key_acc = 1'b1; state_nxt = KEY_WR; end
            KEY_WR:   if (acc_done && idx == 3'd7) state_nxt = CFG_WR;
            CFG_WR:   if (acc_done) state_nxt = INIT_SET;
            INIT_SET: if (acc_done) state_nxt = INIT_CLR;
            INIT_CLR: if (acc_done) state_nxt = WAIT_RDY;
            WAIT_RDY: if (acc_done) begin
                if (reg_rdata[0]) state_nxt = READY;
                else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
                    poll_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            READY: begin
                if (key_load) begin
                    key_acc   = 1'b1;
                    state_nxt = KEY_WR;
                end else if (blk_valid) begin
                    blk_acc   = 1'b1;
                    state_nxt = BLK_WR;
                end
            end
            BLK_WR:   if (acc_done && idx == 3'd3) state_nxt = NEXT_SET;
            NEXT_SET: if (acc_done) state_nxt = NEXT_CLR;
            NEXT_CLR: if (acc_done) state_nxt = WAIT_VLD;
            WAIT_VLD: if (acc_done) begin
                if (reg_rdata[1]) state_nxt = RES_RD;
                else if (poll_cnt == PCW'(POLL_LIMIT - 1)) begin
                    poll_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RES_RD:   if (acc_done && idx == 3'd3) state_nxt = RES_OUT;
            RES_OUT:  if (res_ready) state_nxt = READY;
            default:  state_nxt = IDLE;
        endcase
    end

    // status outputs and the register access each state wants to issue
    always_comb begin
        busy      = !(state == IDLE || state == READY);
        key_ready = (state == READY);
        blk_ready = (state == READY) && !key_load;
        res_valid = (state == RES_OUT);
        acc_need  = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = '0;
        acc_wdata = '0;
        case (state)
            KEY_WR: begin
                acc_addr  = ADDR_W'(32'd24 + 32'(idx) * 32'd4);
                acc_wdata = key_w[idx];
            end
            CFG_WR: begin
                acc_addr  = ADDR_W'(4);
                acc_wdata = {31'b0, keylen_q};
            end
            INIT_SET: acc_wdata = 32'd1;
            INIT_CLR: acc_wdata = 32'd0;
            WAIT_RDY, WAIT_VLD: begin
                acc_we   = 1'b0;
                acc_addr = ADDR_W'(8);
            end
            BLK_WR: begin
                acc_addr  = ADDR_W'(32'd56 + 32'(idx) * 32'd4);
                acc_wdata = blk_w[idx[1:0]];
            end
            NEXT_SET: acc_wdata = 32'd2;
            NEXT_CLR: acc_wdata = 32'd0;
            RES_RD: begin
                acc_we   = 1'b0;
                acc_addr = ADDR_W'(32'd72 + 32'(idx) * 32'd4);
            end
            default: begin
                acc_need = 1'b0;
                acc_we   = 1'b0;
            end
        endcase
    end

    // bus master, operand capture, word index, poll counter, result assembly
    always_ff @(posedge aclk) begin
        if (areset) begin
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            idx       <= '0;
            poll_cnt  <= '0;
            err       <= 1'b0;
            res_data  <= '0;
            keylen_q  <= 1'b0;
            for (int i = 0; i < 8; i++) key_w[i] <= '0;
            for (int i = 0; i < 4; i++) blk_w[i] <= '0;
        end else begin
            if (key_acc) begin
                err      <= 1'b0;
                keylen_q <= keylen;
                for (int i = 0; i < 8; i++) key_w[i] <= key[255-32*i -: 32];
            end
            if (blk_acc) begin
                for (int i = 0; i < 4; i++) blk_w[i] <= blk_data[127-32*i -: 32];
            end
            if (poll_to) err <= 1'b1;

            // req drops after ack, guaranteeing at least one idle cycle between accesses
            if (acc_done) begin
                reg_req <= 1'b0;
            end else if (!reg_req && acc_need) begin
                reg_req   <= 1'b1;
                reg_we    <= acc_we;
                reg_addr  <= acc_addr;
                reg_wdata <= acc_wdata;
            end

            if (state_nxt != state) idx <= '0;
            else if (acc_done)      idx <= idx + 3'd1;

            if (state != WAIT_RDY && state != WAIT_VLD) poll_cnt <= '0;
            else if (acc_done)                          poll_cnt <= poll_cnt + PCW'(1);

            if (acc_done && state == RES_RD) begin
                for (int i = 0; i < 4; i++) begin
                    if (idx[1:0] == 2'(i)) res_data[127-32*i -: 32] <= reg_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_ctr_seq.sv
// tb_aes_ctr_seq: randomized bench with a register-level AES core stub and a
// transaction-level model of the expected bus sequence and results.
module tb_aes_ctr_seq;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned PLIM   = 16;
    localparam logic [255:0] NIST_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] NIST_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] NIST_CT  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic              aclk = 1'b0;
    logic              areset;
    logic              key_load;
    logic [255:0]      key;
    logic              keylen;
    logic              busy, key_ready, err;
    logic              blk_valid, blk_ready;
    logic [127:0]      blk_data;
    logic              res_valid, res_ready;
    logic [127:0]      res_data;
    logic              reg_req, reg_we;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_ack = 1'b0;
    logic [31:0]       reg_rdata = '0;

    aes_ctr_seq #(.POLL_LIMIT(PLIM), .ADDR_W(ADDR_W)) dut (
        .aclk(aclk), .areset(areset), .key_load(key_load), .key(key), .keylen(keylen),
        .busy(busy), .key_ready(key_ready), .err(err),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // stand-in cipher: the known AES-128 vector, otherwise an arbitrary keyed mix
    function automatic logic [127:0] cipher(input logic [255:0] k, input logic kl,
                                            input logic [127:0] b);
        if (k == NIST_KEY && !kl && b == NIST_PT) return NIST_CT;
        return (b ^ k[255:128]) + {b[63:0], b[127:64]} + (kl ? k[127:0] : 128'h0);
    endfunction

    // ---------------- core register stub (responds on the falling edge) ----------------
    typedef struct packed {logic [ADDR_W-1:0] addr; logic [31:0] data;} wr_t;
    wr_t          wlog[$];
    logic [31:0]  kreg [8];
    logic [31:0]  breg [4];
    logic         cfg0 = 1'b0, st_rdy = 1'b0, st_vld = 1'b0;
    logic [127:0] cres = '0;
    int           rdy_left = 0, vld_left = 0, wcnt = 0;
    logic         in_acc = 1'b0, acked = 1'b0, we0 = 1'b0;
    logic [ADDR_W-1:0] a0 = '0;
    logic [31:0]  d0 = '0;
    int           stat_reads = 0, acc_cnt = 0, viol = 0;
    int           ack_max = 0, rdy_reads = 1, vld_reads = 1;
    bit           never_valid = 1'b0;

    always @(negedge aclk) begin
        int ai;
        if (acked && reg_req) viol++;
        acked = 1'b0;
        reg_ack = 1'b0;
        if (areset) begin
            in_acc = 1'b0;
            st_rdy = 1'b0;
            st_vld = 1'b0;
        end else if (reg_req) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                a0 = reg_addr; we0 = reg_we; d0 = reg_wdata;
                wcnt = int'($urandom_range(ack_max, 0));
            end else if (reg_addr !== a0 || reg_we !== we0 || reg_wdata !== d0) begin
                viol++;
            end
            if (wcnt == 0) begin
                ai = int'(reg_addr);
                if (reg_we) begin
                    wlog.push_back({reg_addr, reg_wdata});
                    if (ai == 0) begin
                        if (reg_wdata[0]) begin st_rdy = 1'b0; rdy_left = rdy_reads; end
                        if (reg_wdata[1]) begin
                            st_vld   = 1'b0;
                            vld_left = never_valid ? 0 : vld_reads;
                            cres = cipher({kreg[0], kreg[1], kreg[2], kreg[3], kreg[4], kreg[5],
                                           kreg[6], kreg[7]}, cfg0,
                                          {breg[0], breg[1], breg[2], breg[3]});
                        end
                    end else if (ai == 4) cfg0 = reg_wdata[0];
                    else if (ai >= 24 && ai <= 52) kreg[(ai-24)/4] = reg_wdata;
                    else if (ai >= 56 && ai <= 68) breg[(ai-56)/4] = reg_wdata;
                end else begin
                    if (ai == 8) begin
                        stat_reads++;
                        if (!st_rdy && rdy_left > 0) begin rdy_left--; if (rdy_left == 0) st_rdy = 1'b1; end
                        if (!st_vld && vld_left > 0) begin vld_left--; if (vld_left == 0) st_vld = 1'b1; end
                        reg_rdata = {30'b0, st_vld, st_rdy};
                    end else if (ai >= 72 && ai <= 84) begin
                        reg_rdata = cres[127-32*((ai-72)/4) -: 32];
                    end else begin
                        reg_rdata = $urandom;
                    end
                end
                reg_ack = 1'b1;
                in_acc  = 1'b0;
                acked   = 1'b1;
                acc_cnt++;
            end else begin
                wcnt--;
            end
        end
    end

    // ---------------- reference state and transaction tasks ----------------
    logic [255:0] mkey;
    logic         mkl;

    task automatic check_wr(input string tag, input int pos, input int addr, input logic [31:0] data);
        if (pos < wlog.size()) check(tag, 256'(wlog[pos]), 256'({ADDR_W'(addr), data}));
    endtask

    task automatic do_load(input logic [255:0] k, input logic kl);
        int base, s0, n;
        base = wlog.size();
        s0 = stat_reads;
        rdy_reads = int'($urandom_range(4, 1));
        key = k; keylen = kl; key_load = 1'b1;
        @(posedge aclk); #1;
        key_load = 1'b0; key = ~k; keylen = ~kl;
        check("load_start", {busy, key_ready, err}, 3'b100);
        n = 0;
        while (!key_ready && n < 3000) begin @(posedge aclk); #1; n++; end
        check("key_ready", key_ready, 1'b1);
        mkey = k; mkl = kl;
        check("load_nwr", wlog.size() - base, 11);
        for (int i = 0; i < 8; i++) check_wr("key_wr", base + i, 24 + 4*i, k[255-32*i -: 32]);
        check_wr("cfg_wr", base + 8, 4, {31'b0, kl});
        check_wr("init_set", base + 9, 0, 32'd1);
        check_wr("init_clr", base + 10, 0, 32'd0);
        check("rdy_polls", stat_reads - s0, rdy_reads);
    endtask

    task automatic do_block(input logic [127:0] b, input int hold, input bit exp_to);
        int base, s0, n, ac, bad;
        logic [127:0] r;
        base = wlog.size();
        s0 = stat_reads;
        vld_reads = int'($urandom_range(4, 1));
        blk_valid = 1'b1; blk_data = b;
        n = 0;
        while (!blk_ready && n < 200) begin @(posedge aclk); #1; n++; end
        check("blk_ready", blk_ready, 1'b1);
        @(posedge aclk); #1;
        blk_valid = 1'b0;
        blk_data = {$urandom, $urandom, $urandom, $urandom};
        check("blk_taken", {busy, blk_ready, key_ready}, 3'b100);
        n = 0;
        while (!res_valid && busy && n < 3000) begin @(posedge aclk); #1; n++; end
        check("blk_nwr", wlog.size() - base, 6);
        for (int i = 0; i < 4; i++) check_wr("blk_wr", base + i, 56 + 4*i, b[127-32*i -: 32]);
        check_wr("next_set", base + 4, 0, 32'd2);
        check_wr("next_clr", base + 5, 0, 32'd0);
        if (exp_to) begin
            check("to_flags", {err, busy, key_ready, res_valid}, 4'b1000);
            check("to_polls", stat_reads - s0, PLIM);
        end else begin
            check("res_valid", res_valid, 1'b1);
            check("vld_polls", stat_reads - s0, vld_reads);
            r = res_data; ac = acc_cnt; bad = 0;
            for (int i = 0; i < hold; i++) begin
                @(posedge aclk); #1;
                if (res_valid !== 1'b1 || res_data !== r || blk_ready !== 1'b0) bad++;
            end
            check("hold_stable", bad, 0);
            check("hold_no_bus", acc_cnt - ac, 0);
            check("res_data", res_data, cipher(mkey, mkl, b));
            res_ready = 1'b1;
            @(posedge aclk); #1;
            res_ready = 1'b0;
            check("res_done", {res_valid, key_ready, blk_ready}, 3'b011);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

    initial begin
        logic [255:0] k;
        int base, n;
        areset = 1'b1; key_load = 1'b0; key = '0; keylen = 1'b0;
        blk_valid = 1'b0; blk_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_ctl", {busy, key_ready, err, blk_ready, res_valid, reg_req, reg_we}, 7'b0);
        check("rst_res", res_data, 128'h0);
        check("rst_bus", {reg_addr, reg_wdata}, 40'h0);
        areset = 1'b0;
        @(posedge aclk); #1;

        // known key and vector with zero-wait core, then a long result stall
        do_load(NIST_KEY, 1'b0);
        do_block(NIST_PT, 20, 1'b0);

        // core never reports valid: poll limit, then key_load clears err
        never_valid = 1'b1;
        do_block({$urandom, $urandom, $urandom, $urandom}, 0, 1'b1);
        never_valid = 1'b0;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        do_load(k, 1'b1);

        // random ack latency, back-to-back blocks
        ack_max = 7;
        for (int j = 0; j < 6; j++)
            do_block({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(3, 0)), 1'b0);

        // key_load in READY together with blk_valid: key reload wins
        blk_valid = 1'b1; blk_data = NIST_PT;
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        key = k; keylen = 1'b0; key_load = 1'b1;
        #1;
        check("kl_wins_rdy", blk_ready, 1'b0);
        key_load = 1'b0; blk_valid = 1'b0;
        ack_max = 0;
        base = wlog.size();
        n = 0;
        while (!key_ready && n < 3000) begin @(posedge aclk); #1; n++; end
        mkey = '0; mkl = 1'b0;

        // reset in the middle of the fourth key write, then a full reload
        base = wlog.size();
        for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
        ack_max = 3;
        key = k; keylen = 1'b0; key_load = 1'b1;
        @(posedge aclk); #1;
        key_load = 1'b0;
        n = 0;
        while (!(wlog.size() == base + 3 && reg_req) && n < 500) begin @(posedge aclk); #1; n++; end
        check("mid_addr", {reg_req, reg_we, reg_addr}, {2'b11, ADDR_W'(36)});
        areset = 1'b1;
        @(posedge aclk); #1;
        check("mid_rst_ctl", {busy, key_ready, err, blk_ready, res_valid, reg_req, reg_we}, 7'b0);
        check("mid_rst_bus", {reg_addr, reg_wdata, res_data}, 168'h0);
        areset = 1'b0;
        @(posedge aclk); #1;
        do_load(k, 1'b0);
        do_block({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0);

        check("bus_rules", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
